// File: rtl/pow_sqm.sv
// pow_sqm: square-and-multiply power engine, MSB-first, fixed latency.
// Signed/unsigned base per op; SAT selects modular or saturating result.
module pow_sqm #(
  parameter int BASE_W = 16,
  parameter int EXP_W  = 16,
  parameter int RES_W  = 32,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sgn,
  input  logic [BASE_W-1:0] base,
  input  logic [EXP_W-1:0]  expo,
  output logic              ready,
  output logic [RES_W-1:0]  result,
  output logic              Cflag,
  output logic              Oflag
);

  localparam int CW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int PW = 2 * RES_W + 2;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic              ph;
  logic [BASE_W-1:0] base_q;
  logic [EXP_W-1:0]  expo_q;
  logic              sgn_q;
  logic [RES_W-1:0]  base_x;
  logic              err_q;
  logic [RES_W-1:0]  acc;
  logic              ovf;
  logic [CW-1:0]     cnt;

  logic              load;
  logic [RES_W-1:0]  bext;
  logic              err_n;
  logic [PW-1:0]     p_sq;
  logic [PW-1:0]     p_mul;
  logic [RES_W-1:0]  a1;
  logic [RES_W-1:0]  a2;
  logic              bit_c;
  logic              ovf_n;
  logic              neg;
  logic [RES_W-1:0]  sat_v;
  logic [RES_W-1:0]  res_n;

  function automatic logic signed [PW-1:0] sx(
    input logic [RES_W-1:0] v,
    input logic             s
  );
    sx = {{(RES_W+2){s & v[RES_W-1]}}, v};
  endfunction

  // Product fits RES_W in the selected sign mode.
  function automatic logic fits(
    input logic [PW-1:0] p,
    input logic          s
  );
    if (s)
      fits = (&p[PW-1:RES_W-1]) | ~(|p[PW-1:RES_W-1]);
    else
      fits = ~(|p[PW-1:RES_W]);
  endfunction

  assign load = start & ((state == IDLE) | (state == DONE));

  always_comb begin
    bext = {RES_W{sgn_q & base_q[BASE_W-1]}};
    bext[BASE_W-1:0] = base_q;
    err_n = expo_q[EXP_W-1] | (~(|base_q) & ~(|expo_q));
  end

  always_comb begin
    bit_c = expo_q[cnt];
    p_sq  = sx(acc, sgn_q) * sx(acc, sgn_q);
    a1    = p_sq[RES_W-1:0];
    p_mul = sx(a1, sgn_q) * sx(base_x, sgn_q);
    a2    = bit_c ? p_mul[RES_W-1:0] : a1;
    ovf_n = ovf | ~fits(p_sq, sgn_q)
          | (bit_c & ~fits(p_mul, sgn_q));
    neg   = sgn_q & base_q[BASE_W-1] & expo_q[0];
    unique case (1'b1)
      !sgn_q:  sat_v = '1;
      neg:     sat_v = {1'b1, {(RES_W-1){1'b0}}};
      default: sat_v = {1'b0, {(RES_W-1){1'b1}}};
    endcase
    res_n = ((SAT != 0) && ovf_n) ? sat_v : a2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ph     <= 1'b0;
      base_q <= '0;
      expo_q <= '0;
      sgn_q  <= 1'b0;
      base_x <= '0;
      err_q  <= 1'b0;
      acc    <= RES_W'(1);
      ovf    <= 1'b0;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
      Cflag  <= 1'b0;
      Oflag  <= 1'b0;
    end else if (load) begin
      state  <= LOAD;
      ph     <= 1'b0;
      base_q <= base;
      expo_q <= expo;
      sgn_q  <= sgn;
      ready  <= 1'b0;
      result <= '0;
      Cflag  <= 1'b0;
      Oflag  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        // First LOAD cycle conditions the operands, second dispatches.
        LOAD: begin
          if (!ph) begin
            base_x <= bext;
            err_q  <= err_n;
            ph     <= 1'b1;
          end else begin
            ph <= 1'b0;
            if (err_q) begin
              state  <= DONE;
              ready  <= 1'b1;
              result <= '0;
              Cflag  <= 1'b1;
              Oflag  <= 1'b0;
            end else begin
              state <= RUN;
              acc   <= RES_W'(1);
              ovf   <= 1'b0;
              cnt   <= CW'(EXP_W - 1);
            end
          end
        end
        RUN: begin
          acc <= a2;
          ovf <= ovf_n;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            ready  <= 1'b1;
            result <= res_n;
            Cflag  <= 1'b0;
            Oflag  <= ovf_n;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
